// File: rtl/rx_crc_ctrl_if.sv
// rtl/rx_crc_ctrl_if.sv - receive-side and checker-side signal bundle for the rx CRC sequencer
interface rx_crc_ctrl_if #(
   parameter int CNT_W = 16
);
   // rx front end and CRC checker inputs
   logic             receiving;
   logic             get_terminator;
   logic [2:0]       terminator_location;
   logic             crc_check_valid;
   logic             crc_check_invalid;
   logic             stats_clr;

   // sequencer status and statistics
   logic             wait_crc_check;
   logic [2:0]       term_loc_q;
   logic             crc_ok;
   logic             crc_err;
   logic             crc_timeout;
   logic             rx_abort;
   logic             busy;
   logic [CNT_W-1:0] good_cnt;
   logic [CNT_W-1:0] bad_cnt;

   // sequencer side
   modport slave (
      input  receiving, get_terminator, terminator_location,
             crc_check_valid, crc_check_invalid, stats_clr,
      output wait_crc_check, term_loc_q, crc_ok, crc_err, crc_timeout,
             rx_abort, busy, good_cnt, bad_cnt
   );

   // rx engine side
   modport master (
      output receiving, get_terminator, terminator_location,
             crc_check_valid, crc_check_invalid, stats_clr,
      input  wait_crc_check, term_loc_q, crc_ok, crc_err, crc_timeout,
             rx_abort, busy, good_cnt, bad_cnt
   );
endinterface

// File: rtl/rx_crc_ctrl.sv
// rtl/rx_crc_ctrl.sv - per-frame sequencer for the receive CRC check window and status counters
module rx_crc_ctrl #(
   parameter int CHECK_TIMEOUT = 12,
   parameter int CNT_W         = 16
) (
   input  logic          rxclk,
   input  logic          reset_n,
   rx_crc_ctrl_if.slave  bus
);

   // Timer only has to reach CHECK_TIMEOUT-1; one spare bit keeps the increment simple.
   localparam int TW = $clog2(CHECK_TIMEOUT) + 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(CHECK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RECV,
      ST_WAIT_CHECK,
      ST_DONE
   } state_t;

   state_t           state_q,   state_d;
   logic [TW-1:0]    timer_q,   timer_d;
   logic [2:0]       term_loc_q, term_loc_d;
   logic             wait_q,    wait_d;
   logic             busy_q,    busy_d;
   logic             ok_q,      ok_d;
   logic             err_q,     err_d;
   logic             to_q,      to_d;
   logic             abort_q,   abort_d;
   logic [CNT_W-1:0] good_q,    good_d;
   logic [CNT_W-1:0] bad_q,     bad_d;

   // Next-state, terminator latch, timer and status pulse decisions
   always_comb begin
      state_d    = state_q;
      timer_d    = '0;
      term_loc_d = term_loc_q;
      ok_d       = 1'b0;
      err_d      = 1'b0;
      to_d       = 1'b0;
      abort_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.receiving) begin
               if (bus.get_terminator) begin
                  // Single-word frame: terminator arrives with the first receiving cycle.
                  term_loc_d = bus.terminator_location;
                  state_d    = ST_WAIT_CHECK;
               end else begin
                  state_d = ST_RECV;
               end
            end
         end

         ST_RECV: begin
            // A terminator beats a simultaneous drop of receiving.
            if (bus.get_terminator) begin
               term_loc_d = bus.terminator_location;
               state_d    = ST_WAIT_CHECK;
            end else if (!bus.receiving) begin
               abort_d = 1'b1;
               state_d = ST_IDLE;
            end
         end

         ST_WAIT_CHECK: begin
            // Strobes are checked before the timer so a late strobe still counts as the verdict.
            if (bus.crc_check_invalid) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else if (bus.crc_check_valid) begin
               ok_d    = 1'b1;
               state_d = ST_DONE;
            end else if (timer_q == TIMER_LAST) begin
               err_d   = 1'b1;
               to_d    = 1'b1;
               state_d = ST_DONE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end

         ST_DONE: begin
            // Back-to-back frames: the next frame may already be arriving.
            if (bus.get_terminator) begin
               term_loc_d = bus.terminator_location;
               state_d    = ST_WAIT_CHECK;
            end else if (bus.receiving) begin
               state_d = ST_RECV;
            end else begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      wait_d = (state_d == ST_WAIT_CHECK);
      busy_d = (state_d != ST_IDLE);
   end

   // Saturating frame counters, cleared by stats_clr in preference to counting
   always_comb begin
      good_d = good_q;
      bad_d  = bad_q;
      if (bus.stats_clr) begin
         good_d = '0;
         bad_d  = '0;
      end else begin
         if (ok_q && (good_q != {CNT_W{1'b1}})) begin
            good_d = good_q + CNT_W'(1);
         end
         if (err_q && (bad_q != {CNT_W{1'b1}})) begin
            bad_d = bad_q + CNT_W'(1);
         end
      end
   end

   // State, timer and registered outputs; reset drops any frame in flight silently
   always_ff @(posedge rxclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         timer_q    <= '0;
         term_loc_q <= '0;
         wait_q     <= 1'b0;
         busy_q     <= 1'b0;
         ok_q       <= 1'b0;
         err_q      <= 1'b0;
         to_q       <= 1'b0;
         abort_q    <= 1'b0;
         good_q     <= '0;
         bad_q      <= '0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         term_loc_q <= term_loc_d;
         wait_q     <= wait_d;
         busy_q     <= busy_d;
         ok_q       <= ok_d;
         err_q      <= err_d;
         to_q       <= to_d;
         abort_q    <= abort_d;
         good_q     <= good_d;
         bad_q      <= bad_d;
      end
   end

   assign bus.wait_crc_check = wait_q;
   assign bus.term_loc_q     = term_loc_q;
   assign bus.crc_ok         = ok_q;
   assign bus.crc_err        = err_q;
   assign bus.crc_timeout    = to_q;
   assign bus.rx_abort       = abort_q;
   assign bus.busy           = busy_q;
   assign bus.good_cnt       = good_q;
   assign bus.bad_cnt        = bad_q;

endmodule
